prog_streamer: RTL and testbench

- Burst sequencer for the core programmer interface: the host arms a burst (target core or broadcast, start PC, word count), then pushes instruction words into a small FIFO.
- The block drains the FIFO onto prog_we/prog_sel/prog_waddr/prog_wdata, auto-incrementing the address.
- Sits between the wishbone mux outputs and the instruction memories, and arbitrates against direct single-word programmer writes. Direct writes always win.

---
 rtl/prog_streamer_pkg.sv | 16 +
 rtl/prog_fifo.sv | 40 ++++
 rtl/prog_streamer.sv | 113 +++++++++++
 tb/tb_prog_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_streamer_pkg.sv
// prog_streamer_pkg: shared widths, register map and state type for the burst programmer
package prog_streamer_pkg;
  localparam int DEF_LOG_CORES   = 3;
  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_INSTR_WIDTH = 32;
  localparam int DEF_WB_WIDTH    = 32;
  typedef enum logic [1:0] {REG_CTRL, REG_DATA, REG_STATUS, REG_ABORT} reg_e;
  localparam int CTRL_SEL    = 8;
  localparam int CTRL_BCAST  = 15;
  localparam int CTRL_COUNT  = 16;
  localparam int ST_LEVEL    = 16;
  localparam int ST_CMD_ERR  = 29;
  localparam int ST_OVERFLOW = 30;
  localparam int ST_BUSY     = 31;
  typedef enum logic {IDLE, STREAM} state_e;
endpackage

// File: rtl/prog_fifo.sv
// prog_fifo: power-of-two ring buffer with push/pop/flush and occupancy level
module prog_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign dout  = mem[rd_ptr];
  assign full  = level[AW];
  assign empty = level == '0;
endmodule

// File: rtl/prog_streamer.sv
// prog_streamer: host-armed burst sequencer feeding the core instruction memories
module prog_streamer import prog_streamer_pkg::*; #(
  parameter int LOG_CORES   = DEF_LOG_CORES,
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int WB_WIDTH    = DEF_WB_WIDTH,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_we,
  input  logic [1:0]             cmd_addr,
  input  logic [WB_WIDTH-1:0]    cmd_wdata,
  output logic [WB_WIDTH-1:0]    cmd_rdata,
  input  logic                   dir_we,
  input  logic [LOG_CORES-1:0]   dir_sel,
  input  logic [PC_WIDTH-1:0]    dir_waddr,
  input  logic [INSTR_WIDTH-1:0] dir_wdata,
  output logic                   prog_we,
  output logic [LOG_CORES-1:0]   prog_sel,
  output logic [PC_WIDTH-1:0]    prog_waddr,
  output logic [INSTR_WIDTH-1:0] prog_wdata,
  output logic                   done
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = PC_WIDTH + 1;
  state_e state, state_nx;
  logic [PC_WIDTH-1:0] addr_q;
  logic [LOG_CORES-1:0] core_q;
  logic bcast_q, overflow, cmd_err;
  logic [RW-1:0] remaining, count;
  logic is_ctrl, is_data, abort, busy, issue, last, pop, push, start, finish, full, empty;
  logic [LW-1:0] level;
  logic [INSTR_WIDTH-1:0] head;
  logic unused_ok;
  assign unused_ok = ^cmd_wdata;
  assign is_ctrl = cmd_we && cmd_addr == REG_CTRL;
  assign is_data = cmd_we && cmd_addr == REG_DATA;
  assign abort   = cmd_we && cmd_addr == REG_ABORT;
  assign count   = cmd_wdata[CTRL_COUNT +: RW];
  assign busy    = state == STREAM;
  assign issue   = busy && !empty && !dir_we && !abort;
  // a broadcast word only retires once the last core has been written
  assign last    = !bcast_q || &core_q;
  assign pop     = issue && last;
  // words already queued must never exceed what the burst still needs
  assign push    = is_data && busy && (!full || pop) && RW'(level) < remaining;
  assign start   = is_ctrl && !busy && count != '0;
  assign finish  = pop && remaining == RW'(1);
  prog_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .din   (cmd_wdata[INSTR_WIDTH-1:0]),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (abort || finish) ? IDLE : start ? STREAM : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr_q    <= '0;
      core_q    <= '0;
      bcast_q   <= 1'b0;
      remaining <= '0;
      overflow  <= 1'b0;
      cmd_err   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= finish || (abort && busy);
      if (abort) begin
        remaining <= '0;
        core_q    <= '0;
        overflow  <= 1'b0;
        cmd_err   <= 1'b0;
      end else begin
        if (start) begin
          addr_q    <= cmd_wdata[PC_WIDTH-1:0];
          bcast_q   <= cmd_wdata[CTRL_BCAST];
          core_q    <= cmd_wdata[CTRL_BCAST] ? '0 : cmd_wdata[CTRL_SEL +: LOG_CORES];
          remaining <= count;
        end else if (issue) begin
          core_q <= bcast_q ? core_q + LOG_CORES'(1) : core_q;
          if (last) begin
            addr_q    <= addr_q + PC_WIDTH'(1);
            remaining <= remaining - RW'(1);
          end
        end
        if (is_ctrl && busy) cmd_err <= 1'b1;
        if (is_data && !push) overflow <= 1'b1;
      end
    end
  always_comb begin
    prog_we    = dir_we || issue;
    prog_sel   = dir_we ? dir_sel : issue ? core_q : '0;
    prog_waddr = dir_we ? dir_waddr : issue ? addr_q : '0;
    prog_wdata = dir_we ? dir_wdata : issue ? head : '0;
  end
  always_comb begin
    cmd_rdata              = '0;
    cmd_rdata[RW-1:0]      = remaining;
    cmd_rdata[ST_LEVEL +: LW] = level;
    cmd_rdata[ST_CMD_ERR]  = cmd_err;
    cmd_rdata[ST_OVERFLOW] = overflow;
    cmd_rdata[ST_BUSY]     = busy;
  end
endmodule

// File: tb/tb_prog_streamer.sv
// tb_prog_streamer: queue-based reference model with directed bursts and random traffic
module tb_prog_streamer;
  localparam int CORES = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_we = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [31:0] cmd_rdata;
  logic dir_we = 1'b0;
  logic [2:0] dir_sel = 3'd0;
  logic [7:0] dir_waddr = 8'd0;
  logic [31:0] dir_wdata = 32'd0;
  logic prog_we, done;
  logic [2:0] prog_sel;
  logic [7:0] prog_waddr;
  logic [31:0] prog_wdata;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  typedef struct {int cyc; int sel; int addr; logic [31:0] data;} wr_t;
  wr_t wlog[$];
  int dlog[$];
  logic [31:0] mq[$];
  int mrem = 0, maddr = 0, mcore = 0;
  bit mbusy = 0, mbc = 0, movf = 0, merr = 0, mdone = 0;

  prog_streamer dut (
    .clk(clk), .rst_n(rst_n), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_rdata(cmd_rdata), .dir_we(dir_we), .dir_sel(dir_sel), .dir_waddr(dir_waddr),
    .dir_wdata(dir_wdata), .prog_we(prog_we), .prog_sel(prog_sel), .prog_waddr(prog_waddr),
    .prog_wdata(prog_wdata), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: outputs from queue contents, then advance one clock
  always @(negedge clk) begin
    logic [31:0] e_st, e_data;
    int e_sel, e_addr, cnt;
    bit e_we, ab, iss, pop, nd, was_busy;
    wr_t w;
    cyc++;
    if (prog_we === 1'b1 && !dir_we) begin
      w.cyc = cyc; w.sel = int'(prog_sel); w.addr = int'(prog_waddr); w.data = prog_wdata;
      wlog.push_back(w);
    end
    if (done === 1'b1) dlog.push_back(cyc);
    ab = rst_n && cmd_we && cmd_addr == 2'd3;
    iss = rst_n && mbusy && mq.size() > 0 && !dir_we && !ab;
    e_we = dir_we || iss;
    e_sel = dir_we ? int'(dir_sel) : iss ? mcore : 0;
    e_addr = dir_we ? int'(dir_waddr) : iss ? maddr : 0;
    e_data = dir_we ? dir_wdata : iss ? mq[0] : 32'd0;
    e_st = rst_n ? (32'(mrem) | (32'(mq.size()) << 16) | (32'(merr) << 29) |
                    (32'(movf) << 30) | (32'(mbusy) << 31)) : 32'd0;
    chk("prog_we", 64'(prog_we), 64'(e_we));
    chk("prog_sel", 64'(prog_sel), 64'(e_sel));
    chk("prog_waddr", 64'(prog_waddr), 64'(e_addr));
    chk("prog_wdata", 64'(prog_wdata), 64'(e_data));
    chk("status", 64'(cmd_rdata), 64'(e_st));
    chk("done", 64'(done), 64'(rst_n ? mdone : 1'b0));
    nd = 0;
    was_busy = mbusy;
    if (!rst_n || ab) begin
      nd = rst_n && mbusy;
      mq.delete(); mrem = 0; mbusy = 0; movf = 0; merr = 0; mcore = 0;
    end else begin
      pop = iss && (!mbc || mcore == CORES - 1);
      if (cmd_we && cmd_addr == 2'd1) begin
        if (was_busy && (mq.size() < DEPTH || pop) && mq.size() < mrem) mq.push_back(cmd_wdata);
        else movf = 1;
      end
      if (iss) begin
        if (mbc) mcore = (mcore + 1) % CORES;
        if (pop) begin
          void'(mq.pop_front());
          maddr = (maddr + 1) % 256;
          mrem--;
          if (mrem == 0) begin mbusy = 0; nd = 1; end
        end
      end
      if (cmd_we && cmd_addr == 2'd0) begin
        cnt = int'((cmd_wdata >> 16) & 32'h1FF);
        if (was_busy) merr = 1;
        else if (cnt != 0) begin
          maddr = int'(cmd_wdata & 32'hFF);
          mbc = cmd_wdata[15];
          mcore = mbc ? 0 : int'((cmd_wdata >> 8) & 32'h7);
          mrem = cnt;
          mbusy = 1;
        end
      end
    end
    mdone = nd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] a, input logic [31:0] d);
    cmd_we = 1'b1; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_we = 1'b0;
  endtask

  function automatic logic [31:0] ctrl(input int pc, input int sel, input bit bc, input int cnt);
    return 32'(pc) | (32'(sel) << 8) | (32'(bc) << 15) | (32'(cnt) << 16);
  endfunction

  task automatic chk_wr(input string nm, input int i, input int s, input int a, input logic [31:0] d, input int c);
    if (i >= wlog.size()) begin
      checks++; errors++;
      $display("FAIL %s: write %0d missing, got %0d writes", nm, i, wlog.size());
    end else begin
      chk({nm, "_sel"}, 64'(wlog[i].sel), 64'(s));
      chk({nm, "_addr"}, 64'(wlog[i].addr), 64'(a));
      chk({nm, "_data"}, 64'(wlog[i].data), 64'(d));
      chk({nm, "_cyc"}, 64'(wlog[i].cyc), 64'(c));
    end
  endtask

  task automatic chk_done(input string nm, input int c);
    if (dlog.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no done pulse, expected cycle %0d", nm, c);
    end else chk(nm, 64'(dlog[0]), 64'(c));
  endtask

  task automatic clr();
    wlog.delete();
    dlog.delete();
  endtask

  initial begin
    int t0, r;
    tick();
    chk("rst_status", 64'(cmd_rdata), 64'd0);
    chk("rst_we", 64'(prog_we), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // plain burst to core 2
    clr(); t0 = cyc + 1;
    cmd(2'd0, ctrl(8'h10, 2, 0, 3));
    cmd(2'd1, 32'hA); cmd(2'd1, 32'hB); cmd(2'd1, 32'hC);
    repeat (4) tick();
    chk("t1_n", 64'(wlog.size()), 64'd3);
    chk_wr("t1_w0", 0, 2, 8'h10, 32'hA, t0 + 2);
    chk_wr("t1_w1", 1, 2, 8'h11, 32'hB, t0 + 3);
    chk_wr("t1_w2", 2, 2, 8'h12, 32'hC, t0 + 4);
    chk_done("t1_done", t0 + 5);
    chk("t1_busy", 64'(cmd_rdata[31]), 64'd0);
    // address wrap
    clr(); t0 = cyc + 1;
    cmd(2'd0, ctrl(8'hFF, 0, 0, 2));
    cmd(2'd1, 32'h1); cmd(2'd1, 32'h2);
    repeat (4) tick();
    chk_wr("t2_w0", 0, 0, 8'hFF, 32'h1, t0 + 2);
    chk_wr("t2_w1", 1, 0, 8'h00, 32'h2, t0 + 3);
    chk_done("t2_done", t0 + 4);
    // broadcast
    clr(); t0 = cyc + 1;
    cmd(2'd0, ctrl(5, 6, 1, 1));
    cmd(2'd1, 32'h77);
    repeat (12) tick();
    chk("t3_n", 64'(wlog.size()), 64'd8);
    for (int i = 0; i < CORES; i++) chk_wr("t3_w", i, i, 5, 32'h77, t0 + 2 + i);
    chk_done("t3_done", t0 + 10);
    // direct writes pre-empt a live stream
    clr(); t0 = cyc + 1;
    cmd(2'd0, ctrl(8'h20, 1, 0, 2));
    cmd(2'd1, 32'h55);
    dir_we = 1'b1; dir_sel = 3'd4; dir_waddr = 8'd9; dir_wdata = 32'hDEAD;
    cmd_we = 1'b1; cmd_addr = 2'd1; cmd_wdata = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_we", 64'(prog_we), 64'd1);
      chk("t4_sel", 64'(prog_sel), 64'd4);
      chk("t4_addr", 64'(prog_waddr), 64'd9);
      chk("t4_data", 64'(prog_wdata), 64'hDEAD);
      if (i == 2) chk("t4_level", 64'(cmd_rdata[18:16]), 64'd2);
      tick();
      cmd_we = 1'b0;
    end
    dir_we = 1'b0;
    repeat (4) tick();
    chk_wr("t4_w0", 0, 1, 8'h20, 32'h55, t0 + 5);
    chk_wr("t4_w1", 1, 1, 8'h21, 32'h66, t0 + 6);
    chk_done("t4_done", t0 + 7);
    // overflow then abort
    cmd(2'd0, ctrl(0, 0, 0, 8));
    dir_we = 1'b1; dir_sel = 3'd0; dir_waddr = 8'd0; dir_wdata = 32'd0;
    for (int i = 0; i < 5; i++) cmd(2'd1, 32'h100 + 32'(i));
    chk("t5_level", 64'(cmd_rdata[18:16]), 64'd4);
    chk("t5_ovf", 64'(cmd_rdata[30]), 64'd1);
    cmd(2'd3, 32'd0);
    chk("t5_level0", 64'(cmd_rdata[18:16]), 64'd0);
    chk("t5_ovf0", 64'(cmd_rdata[30]), 64'd0);
    chk("t5_busy0", 64'(cmd_rdata[31]), 64'd0);
    chk("t5_done", 64'(done), 64'd1);
    dir_we = 1'b0;
    tick();
    chk("t5_done0", 64'(done), 64'd0);
    // CTRL while busy
    cmd(2'd0, ctrl(0, 0, 0, 2));
    cmd(2'd0, ctrl(3, 3, 0, 5));
    chk("t6_err", 64'(cmd_rdata[29]), 64'd1);
    chk("t6_rem", 64'(cmd_rdata[8:0]), 64'd2);
    cmd(2'd3, 32'd0);
    chk("t6_err0", 64'(cmd_rdata[29]), 64'd0);
    // reset mid-burst
    cmd(2'd0, ctrl(8'h40, 3, 0, 4));
    cmd(2'd1, 32'h1); cmd(2'd1, 32'h2);
    rst_n = 1'b0;
    #1;
    chk("t7_we", 64'(prog_we), 64'd0);
    chk("t7_status", 64'(cmd_rdata), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t7_status_after", 64'(cmd_rdata), 64'd0);
    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      dir_we = $urandom_range(0, 7) == 0;
      dir_sel = 3'($urandom); dir_waddr = 8'($urandom); dir_wdata = $urandom;
      cmd_we = $urandom_range(0, 99) < 45;
      r = $urandom_range(0, 39);
      cmd_addr = r < 4 ? 2'd0 : r < 36 ? 2'd1 : r < 39 ? 2'd2 : 2'd3;
      cmd_wdata = $urandom;
      if (cmd_addr == 2'd0) cmd_wdata[24:16] = 9'($urandom_range(0, 10));
      rst_n = $urandom_range(0, 1499) != 0;
      tick();
    end
    cmd_we = 1'b0; dir_we = 1'b0; rst_n = 1'b1;
    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
